// File: rtl/ct_sram_pkg.sv
// Purpose: shared SRAM constants and read-FSM state type for the colour-transform SRAM paths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: ADDR_W/DATA_W word geometry, CH_PER_PIX channel count, rd_state_t read-FSM states.
package ct_sram_pkg;

  localparam int ADDR_W     = 20;
  localparam int DATA_W     = 16;
  localparam int CH_PER_PIX = 3;

  typedef enum logic [2:0] {
    RD_IDLE,
    RD_ADDR,
    RD_CAP,
    RD_PUSH,
    RD_DRAIN,
    RD_DONE
  } rd_state_t;

endpackage

// File: rtl/pix_out_reg.sv
// Purpose: single-entry valid/ready output register for assembled pixels.
// Latency: 1 cycle from load to valid; zero-bubble reload on the accepting edge.
// Backpressure: holds valid/dat stable until valid&ready; can_load tells the producer a load is safe.
// Ports: clk, rst (sync, active-high); load/load_dat from producer; ready from consumer;
//        valid/dat to consumer; can_load back to producer.
module pix_out_reg #(
  parameter int W = 48
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_dat,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] dat,
  output logic         can_load
);

  // Free now, or emptying on this same edge.
  assign can_load = !valid || ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      dat   <= '0;
    end else if (load) begin
      // Reload wins over a simultaneous accept, so valid stays high.
      valid <= 1'b1;
      dat   <= load_dat;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sram_result_reader.sv
// Purpose: reads a colour-transformed frame back out of async SRAM and streams whole pixels.
// Latency: 2 cycles per SRAM word, 6 per pixel; first oPix_valid 6 edges after start; oDone 6N+2 edges after start.
// Backpressure: a finished pixel waits in PUSH (OE_N high, address held) until the output register frees.
// Ports: clk, rst (sync, active-high); start/iCol_Max/iRow_Max/iBase_Addr frame request;
//        oSRAM_ADDR/oSRAM_DATA/oSRAM_WE_N/oSRAM_OE_N SRAM read port (DQ never driven);
//        oPix_valid/oPix_data/iPix_ready pixel stream {ch0,ch1,ch2}; oBusy, oDone status.
module sram_result_reader #(
  parameter int ADDR_W = ct_sram_pkg::ADDR_W,
  parameter int DATA_W = ct_sram_pkg::DATA_W,
  parameter int DIM_W  = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DIM_W-1:0]       iCol_Max,
  input  logic [DIM_W-1:0]       iRow_Max,
  input  logic [ADDR_W-1:0]      iBase_Addr,
  output logic [ADDR_W-1:0]      oSRAM_ADDR,
  inout  wire  [DATA_W-1:0]      oSRAM_DATA,
  output logic                   oSRAM_WE_N,
  output logic                   oSRAM_OE_N,
  output logic                   oPix_valid,
  output logic [3*DATA_W-1:0]    oPix_data,
  input  logic                   iPix_ready,
  output logic                   oBusy,
  output logic                   oDone
);

  import ct_sram_pkg::*;

  localparam int         PIX_W   = 2 * DIM_W;
  localparam logic [1:0] LAST_CH = 2'(CH_PER_PIX - 1);

  rd_state_t           state;
  logic [1:0]          ch;
  logic [PIX_W-1:0]    pix;
  logic [PIX_W-1:0]    n_pix;
  logic [DATA_W-1:0]   ch0_q;
  logic [DATA_W-1:0]   ch1_q;
  logic [DATA_W-1:0]   ch2_q;
  logic                last_pix;
  logic                can_load;
  logic                load;
  logic [3*DATA_W-1:0] load_dat;

  // Read-only port: DQ is left floating for the SRAM to drive.
  assign oSRAM_DATA = {DATA_W{1'bz}};
  assign oSRAM_WE_N = 1'b1;
  assign oBusy      = (state != RD_IDLE);

  assign last_pix = (pix == n_pix - 1'b1);

  // In RD_CAP the third channel goes straight from DQ into the output register;
  // from PUSH it comes from the assembly register captured earlier.
  assign load = can_load && (((state == RD_CAP) && (ch == LAST_CH)) || (state == RD_PUSH));
  assign load_dat = (state == RD_CAP) ? {ch0_q, ch1_q, oSRAM_DATA}
                                      : {ch0_q, ch1_q, ch2_q};

  pix_out_reg #(
    .W(3 * DATA_W)
  ) u_pix_out_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_dat (load_dat),
    .ready    (iPix_ready),
    .valid    (oPix_valid),
    .dat      (oPix_data),
    .can_load (can_load)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RD_IDLE;
      oSRAM_ADDR <= '0;
      oSRAM_OE_N <= 1'b1;
      oDone      <= 1'b0;
      ch         <= '0;
      pix        <= '0;
      n_pix      <= '0;
      ch0_q      <= '0;
      ch1_q      <= '0;
      ch2_q      <= '0;
    end else begin
      oDone <= 1'b0;
      case (state)
        RD_IDLE: begin
          if (start) begin
            n_pix <= PIX_W'(iCol_Max) * PIX_W'(iRow_Max);
            ch    <= '0;
            pix   <= '0;
            if ((iCol_Max == '0) || (iRow_Max == '0)) begin
              // Empty frame: finish without touching the SRAM.
              state <= RD_DONE;
            end else begin
              state      <= RD_ADDR;
              oSRAM_ADDR <= iBase_Addr;
              oSRAM_OE_N <= 1'b0;
            end
          end
        end

        RD_ADDR: begin
          // Address has been stable for one cycle; data is sampled at the end of RD_CAP.
          state <= RD_CAP;
        end

        RD_CAP: begin
          case (ch)
            2'd0:    ch0_q <= oSRAM_DATA;
            2'd1:    ch1_q <= oSRAM_DATA;
            default: ch2_q <= oSRAM_DATA;
          endcase
          if (ch != LAST_CH) begin
            ch         <= ch + 2'd1;
            oSRAM_ADDR <= oSRAM_ADDR + 1'b1;
            state      <= RD_ADDR;
          end else if (can_load) begin
            ch <= '0;
            if (last_pix) begin
              state      <= RD_DRAIN;
              oSRAM_OE_N <= 1'b1;
            end else begin
              pix        <= pix + 1'b1;
              oSRAM_ADDR <= oSRAM_ADDR + 1'b1;
              state      <= RD_ADDR;
            end
          end else begin
            state      <= RD_PUSH;
            oSRAM_OE_N <= 1'b1;
          end
        end

        RD_PUSH: begin
          if (can_load) begin
            ch <= '0;
            if (last_pix) begin
              state <= RD_DRAIN;
            end else begin
              pix        <= pix + 1'b1;
              oSRAM_ADDR <= oSRAM_ADDR + 1'b1;
              oSRAM_OE_N <= 1'b0;
              state      <= RD_ADDR;
            end
          end
        end

        RD_DRAIN: begin
          if (!oPix_valid || iPix_ready) begin
            state <= RD_DONE;
          end
        end

        RD_DONE: begin
          oDone <= 1'b1;
          state <= RD_IDLE;
        end

        default: begin
          state      <= RD_IDLE;
          oSRAM_OE_N <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/sram_result_reader.md
# sram_result_reader

Streams the colour-transformed image back out of the board SRAM after `color_transform` has written it. It is the read-side counterpart of the transform's SRAM write path. On `start` it walks the result region, fetches three 16-bit channel words per pixel over the asynchronous SRAM port, and presents whole pixels on a valid/ready stream for the display or UART back-end.

## Interface
Parameters:
- `ADDR_W`, 20: SRAM word-address width.
- `DATA_W`, 16: SRAM word width; one channel per word.
- `DIM_W`, 10: width of the column and row counts.

Ports (clock and reset first):
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  begin one frame readout; sampled only in IDLE.
- `iCol_Max`  in  DIM_W  number of columns in the frame.
- `iRow_Max`  in  DIM_W  number of rows in the frame.
- `iBase_Addr`  in  ADDR_W  word address of channel 0 of pixel 0.
- `oSRAM_ADDR`  out  ADDR_W  SRAM address.
- `oSRAM_DATA`  inout  DATA_W  SRAM DQ; this block always drives it high-Z.
- `oSRAM_WE_N`  out  1  write enable; constant 1.
- `oSRAM_OE_N`  out  1  output enable, active low.
- `oPix_valid`  out  1  output pixel register is full.
- `oPix_data`  out  3*DATA_W  pixel data as {ch0, ch1, ch2}.
- `iPix_ready`  in  1  downstream accepts the pixel.
- `oBusy`  out  1  high in every state except IDLE.
- `oDone`  out  1  one-cycle pulse at frame end.

## Operation
- Memory layout: channel c of pixel p is at `iBase_Addr + 3*p + c`, computed mod 2^ADDR_W so the address wraps past 0xFFFFF.
- Pixel count N = iCol_Max*iRow_Max. `iCol_Max`, `iRow_Max` and `iBase_Addr` are latched when `start` is accepted.
- States:
  - IDLE: on `start`, go to RD_ADDR with channel=0 and pixel=0. If N=0, go to DONE instead.
  - RD_ADDR: drive the address and hold `oSRAM_OE_N`=0. Next state is RD_CAP.
  - RD_CAP: keep the address and OE_N=0. At the end of the cycle, capture `oSRAM_DATA` into channel slot c of the assembly register.
    - If c<2: c++, go to RD_ADDR.
    - If c=2 and the output register is free, or is being accepted this edge: load the output register, then go to RD_ADDR for the next pixel, or to DRAIN after the last pixel.
    - Otherwise go to PUSH.
  - PUSH: OE_N=1 and the address is held. Load the output register on the edge where it empties, with no bubble. Then go to RD_ADDR or DRAIN.
  - DRAIN: wait until the final pixel is accepted, then go to DONE.
  - DONE: `oDone`=1 for one cycle, then IDLE.
- Output register: `oPix_valid` stays high and `oPix_data` stays stable until a cycle with valid&ready. If accept and reload happen on the same edge, reload wins and valid stays high.
- `start` asserted while busy is ignored. `rst` aborts any frame, and no partial pixel is ever emitted.
- `oSRAM_WE_N` is never low. `oSRAM_DATA` is never driven.

## Timing
- Reset values:
  - state IDLE.
  - `oSRAM_OE_N`=1, `oSRAM_WE_N`=1.
  - `oSRAM_ADDR`=0.
  - `oPix_valid`=0, `oPix_data`=0.
  - `oBusy`=0, `oDone`=0.
- SRAM read: the address is registered at edge k and the data is sampled at edge k+2. That is 2 cycles per word and 6 cycles per pixel.
- `start` is sampled at edge e0. The address for pixel 0 channel 0 appears after e0, and `oPix_valid` rises after e6.
- With `iPix_ready` held at 1, throughput is 1 pixel per 6 cycles. A frame takes 6N+2 cycles from the `start` edge to the `oDone` pulse, including DRAIN and DONE.
- For N=0: `oDone` pulses in the second cycle after `start`, and the SRAM is not accessed.

## Structure
- Shared package `ct_sram_pkg`: `ADDR_W`/`DATA_W` constants, the `rd_state_t` enum, and the `CH_PER_PIX`=3 constant. The package is reused by `color_transform`.
- One sub-module: `pix_out_reg`, the single-entry valid/ready output register with load/accept handling.
- The channel counter, pixel counter and address adder stay in the top module.

## Test plan
- 2x2 frame, base 0x00100, SRAM preloaded with value = address. Ready held at 1 -> pixels {0x100,0x101,0x102} … {0x109,0x10A,0x10B}, first valid 6 cycles after start, `oDone` after 26 cycles, WE_N always 1.
- Same frame with ready low for 20 cycles after the first valid -> pixel 1 is assembled and held in PUSH with OE_N=1, and no pixel is lost or repeated.
- iCol_Max=0, iRow_Max=7 -> `oDone` 2 cycles after start, `oPix_valid` never asserts, no OE_N low.
- Base 0xFFFFE, 1x1 frame -> addresses 0xFFFFE, 0xFFFFF, 0x00000 in sequence.
- `rst` asserted mid-pixel in RD_CAP -> all outputs at reset values the next cycle. A new start reads from pixel 0 again.
- `start` pulsed again during a busy frame -> ignored, and the frame completes with exactly N pixels and one `oDone`.
